// File: rtl/sram_pkg.sv
// Shared types and constants for the external SRAM controller.
// No logic: state encoding and control-word bit positions only.
// Imported by sram_controller.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Bit positions inside the decoder's 5-bit sram_control word
    localparam int INH = 4;
    localparam int RD  = 2;
    localparam int UB  = 1;
    localparam int LB  = 0;

endpackage

// File: rtl/sram_controller.sv
// Sequences one asynchronous SRAM access per accepted request: setup, strobe, hold.
// Latency: done pulses WAIT_CYCLES+2 cycles after acceptance; next request one cycle later.
// Backpressure: stall holds the CPU from acceptance through the last strobe cycle.
module sram_controller #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [4:0]  sram_control,
    input  logic [17:0] dir_in,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);
    import sram_pkg::*;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic        accept;

    // Values captured at acceptance; the CPU inputs are ignored afterwards
    logic        rd_q;
    logic        ub_q;
    logic        lb_q;
    logic [15:0] wdata_q;

    // Next values of the pin flops, decoded from the next state
    logic        rd_nxt;
    logic        ub_nxt;
    logic        lb_nxt;
    logic        busy_nxt;
    logic        dq_oe;

    // Bit 3 of the control word carries nothing for the SRAM
    logic        unused_ctrl;
    assign unused_ctrl = sram_control[3];

    // Next-state decode; a request is only considered while idle
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req && !sram_control[INH]) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pin values for the coming cycle, using freshly captured fields on acceptance
    always_comb begin
        rd_nxt   = accept ? sram_control[RD] : rd_q;
        ub_nxt   = accept ? sram_control[UB] : ub_q;
        lb_nxt   = accept ? sram_control[LB] : lb_q;
        busy_nxt = (state_nxt != IDLE);
    end

    // State register and strobe-length counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == SETUP)
                wait_cnt <= WAIT_LOAD;
            else if (state == ACCESS && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Capture of the request fields; the address register drives the pins directly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q      <= 1'b0;
            ub_q      <= 1'b1;
            lb_q      <= 1'b1;
            sram_addr <= 18'd0;
            wdata_q   <= 16'd0;
        end else if (accept) begin
            rd_q      <= sram_control[RD];
            ub_q      <= sram_control[UB];
            lb_q      <= sram_control[LB];
            sram_addr <= dir_in;
            wdata_q   <= data_in;
        end
    end

    // Every SRAM control pin and the bus enable come straight from a flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            dq_oe     <= 1'b0;
            done      <= 1'b0;
        end else begin
            sram_ce_n <= !busy_nxt;
            sram_oe_n <= !(rd_nxt && (state_nxt == SETUP || state_nxt == ACCESS));
            sram_we_n <= !(!rd_nxt && state_nxt == ACCESS);
            sram_ub_n <= busy_nxt ? ub_nxt : 1'b1;
            sram_lb_n <= busy_nxt ? lb_nxt : 1'b1;
            dq_oe     <= busy_nxt && !rd_nxt;
            done      <= (state_nxt == HOLD);
        end
    end

    // Read data sampled on the last strobe cycle; disabled byte lanes read as zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= 16'd0;
        end else if (state == ACCESS && wait_cnt == 4'd0 && rd_q) begin
            data_out <= {(ub_q ? 8'h00 : sram_dq[15:8]), (lb_q ? 8'h00 : sram_dq[7:0])};
        end
    end

    assign sram_dq = dq_oe ? wdata_q : 16'hzzzz;
    assign stall   = accept || (state == SETUP) || (state == ACCESS);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural SRAM device, cycle-timeline reference model,
// per-cycle comparison of all outputs, plus directed literal checks.
// A second instance with WAIT_CYCLES=1 checks the shortened timeline.
module tb_sram_controller;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req;
    logic [4:0]  sram_control;
    logic [17:0] dir_in;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        stall;
    logic        done;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic        req1;
    logic [4:0]  ctrl1;
    logic [17:0] dir1;
    logic [15:0] din1;
    logic [15:0] dout1;
    logic        stall1, done1;
    logic [17:0] addr1;
    wire  [15:0] dq1;
    logic        ce1_n, oe1_n, we1_n, ub1_n, lb1_n;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(W)) u0 (
        .clk(clk), .reset(reset), .req(req), .sram_control(sram_control),
        .dir_in(dir_in), .data_in(data_in), .data_out(data_out), .stall(stall),
        .done(done), .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    sram_controller #(.WAIT_CYCLES(1)) u1 (
        .clk(clk), .reset(reset), .req(req1), .sram_control(ctrl1),
        .dir_in(dir1), .data_in(din1), .data_out(dout1), .stall(stall1),
        .done(done1), .sram_addr(addr1), .sram_dq(dq1), .sram_ce_n(ce1_n),
        .sram_oe_n(oe1_n), .sram_we_n(we1_n), .sram_ub_n(ub1_n), .sram_lb_n(lb1_n)
    );

    // Undriven bus floats to all ones so high-Z is observable
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (sram_dq[g]);
        pullup (dq1[g]);
    end

    // Asynchronous SRAM device model
    logic [15:0] mem       [0:262143];
    logic [15:0] model_mem [0:262143];

    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;
    assign dq1     = (!ce1_n && !oe1_n && we1_n) ? 16'h5A3C : 16'hzzzz;

    always @(posedge sram_we_n) begin
        if (!sram_ce_n && reset)
            mem[sram_addr] = {(sram_ub_n ? mem[sram_addr][15:8] : sram_dq[15:8]),
                              (sram_lb_n ? mem[sram_addr][7:0]  : sram_dq[7:0])};
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Reference model: position of the current access on its timeline
    // (-1 idle, 0 acceptance cycle, 1 setup, 2..W+1 strobe, W+2 hold)
    int          k = -1;
    int          k_nxt = -1;
    logic        m_rd, m_ub, m_lb;
    logic [17:0] m_addr;
    logic [15:0] m_data;
    logic [15:0] exp_dout = 16'd0;
    logic [17:0] exp_addr = 18'd0;

    always @(posedge clk or negedge reset) begin
        if (!reset) k = -1;
        else        k = k_nxt;
    end

    // Per-cycle compare of every DUT output against the timeline model
    always @(negedge clk) begin
        int cur;
        if (!reset) begin
            chk("rst_ce_n", 32'(sram_ce_n), 1);
            chk("rst_oe_n", 32'(sram_oe_n), 1);
            chk("rst_we_n", 32'(sram_we_n), 1);
            chk("rst_ub_n", 32'(sram_ub_n), 1);
            chk("rst_lb_n", 32'(sram_lb_n), 1);
            chk("rst_done", 32'(done), 0);
            chk("rst_stall", 32'(stall), 0);
            chk("rst_addr", 32'(sram_addr), 0);
            chk("rst_dout", 32'(data_out), 0);
            chk("rst_dq_z", 32'(sram_dq), 32'hFFFF);
            k_nxt    = -1;
            exp_dout = 16'd0;
            exp_addr = 18'd0;
        end else begin
            cur = k;
            if (k < 0 && req && !sram_control[4]) begin
                cur    = 0;
                m_rd   = sram_control[2];
                m_ub   = sram_control[1];
                m_lb   = sram_control[0];
                m_addr = dir_in;
                m_data = data_in;
            end
            if (cur == 1) exp_addr = m_addr;
            if (cur == W + 2) begin
                if (m_rd)
                    exp_dout = {(m_ub ? 8'h00 : model_mem[m_addr][15:8]),
                                (m_lb ? 8'h00 : model_mem[m_addr][7:0])};
                else
                    model_mem[m_addr] = {(m_ub ? model_mem[m_addr][15:8] : m_data[15:8]),
                                         (m_lb ? model_mem[m_addr][7:0]  : m_data[7:0])};
            end
            chk("stall", 32'(stall), 32'(cur >= 0 && cur <= W + 1));
            chk("done", 32'(done), 32'(cur == W + 2));
            chk("ce_n", 32'(sram_ce_n), 32'(!(cur >= 1)));
            chk("oe_n", 32'(sram_oe_n), 32'(!(m_rd && cur >= 1 && cur <= W + 1)));
            chk("we_n", 32'(sram_we_n), 32'(!(!m_rd && cur >= 2 && cur <= W + 1)));
            chk("ub_n", 32'(sram_ub_n), 32'(cur >= 1 ? m_ub : 1'b1));
            chk("lb_n", 32'(sram_lb_n), 32'(cur >= 1 ? m_lb : 1'b1));
            chk("addr", 32'(sram_addr), 32'(exp_addr));
            chk("dout", 32'(data_out), 32'(exp_dout));
            if (!m_rd && cur >= 1)
                chk("dq_wr", 32'(sram_dq), 32'(m_data));
            else if (!(m_rd && cur >= 1 && cur <= W + 1))
                chk("dq_z", 32'(sram_dq), 32'hFFFF);
            k_nxt = (cur < 0 || cur >= W + 2) ? -1 : cur + 1;
        end
    end

    // One access on u0; inputs are scrambled after acceptance to show they are ignored
    task automatic do_access(input logic [4:0] c, input logic [17:0] a, input logic [15:0] d,
                             output logic [15:0] r, output int dc);
        req = 1'b1; sram_control = c; dir_in = a; data_in = d;
        dc = -1;
        r  = 16'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = i;
                r  = data_out;
                break;
            end
            @(posedge clk); #2;
            req = 1'b0; sram_control = 5'b00000; dir_in = ~a; data_in = ~d;
        end
        @(posedge clk); #2;
    endtask

    logic [15:0] r;
    int          dc;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        req = 0; sram_control = 0; dir_in = 0; data_in = 0;
        req1 = 0; ctrl1 = 0; dir1 = 0; din1 = 0;
        mem[18'h00010] = 16'h1A2B; model_mem[18'h00010] = 16'h1A2B;
        mem[18'h00100] = 16'hFFFF; model_mem[18'h00100] = 16'hFFFF;
        mem[18'h3FFFF] = 16'h0000; model_mem[18'h3FFFF] = 16'h0000;
        mem[18'h00020] = 16'h0000; model_mem[18'h00020] = 16'h0000;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Read with default wait: done in c4
        do_access(5'b00100, 18'h00010, 16'h0000, r, dc);
        chk("rd_done_cycle", 32'(dc), 4);
        chk("rd_data", 32'(r), 32'h1A2B);

        // Write then read back at the top address
        do_access(5'b00000, 18'h3FFFF, 16'hBEEF, r, dc);
        chk("wr_done_cycle", 32'(dc), 4);
        chk("wr_mem", 32'(mem[18'h3FFFF]), 32'hBEEF);
        chk("wr_keeps_dout", 32'(data_out), 32'h1A2B);
        do_access(5'b00100, 18'h3FFFF, 16'h0000, r, dc);
        chk("rdback_data", 32'(r), 32'hBEEF);

        // Byte lanes: upper lane only written, then each lane read alone
        do_access(5'b00001, 18'h00100, 16'h1234, r, dc);
        chk("bl_mem", 32'(mem[18'h00100]), 32'h12FF);
        do_access(5'b00110, 18'h00100, 16'h0000, r, dc);
        chk("bl_rd_low", 32'(r), 32'h00FF);
        do_access(5'b00101, 18'h00100, 16'h0000, r, dc);
        chk("bl_rd_high", 32'(r), 32'h1200);

        // IO inhibit: nothing happens
        req = 1'b1; sram_control = 5'b10000; dir_in = 18'h00010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("io_stall", 32'(stall), 0);
            chk("io_ce_n", 32'(sram_ce_n), 1);
            @(posedge clk); #2;
        end
        req = 1'b0; sram_control = 5'b00000;

        // Reset in the middle of a write strobe
        req = 1'b1; sram_control = 5'b00000; dir_in = 18'h00020; data_in = 16'h5555;
        @(posedge clk); #2;
        req = 1'b0;
        @(posedge clk); #2;
        chk("mid_we_low", 32'(sram_we_n), 0);
        #1 reset = 1'b0;
        #1;
        chk("arst_we_n", 32'(sram_we_n), 1);
        chk("arst_ce_n", 32'(sram_ce_n), 1);
        chk("arst_oe_n", 32'(sram_oe_n), 1);
        chk("arst_dq_z", 32'(sram_dq), 32'hFFFF);
        chk("arst_done", 32'(done), 0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        do_access(5'b00100, 18'h00010, 16'h0000, r, dc);
        chk("post_rst_done_cycle", 32'(dc), 4);
        chk("post_rst_data", 32'(r), 32'h1A2B);

        // WAIT_CYCLES=1 instance: done in c3
        req1 = 1'b1; ctrl1 = 5'b00100; dir1 = 18'h00005; din1 = 16'h0000;
        dc = -1;
        r  = 16'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("w1_stall_c0", 32'(stall1), 1);
            if (i == 1) chk("w1_oe_c1", 32'(oe1_n), 0);
            if (i == 2) chk("w1_oe_c2", 32'(oe1_n), 0);
            if (done1 === 1'b1) begin
                dc = i;
                r  = dout1;
                chk("w1_stall_hold", 32'(stall1), 0);
                chk("w1_oe_hold", 32'(oe1_n), 1);
                break;
            end
            @(posedge clk); #2;
            req1 = 1'b0;
        end
        chk("w1_done_cycle", 32'(dc), 3);
        chk("w1_data", 32'(r), 32'h5A3C);
        req1 = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
